axi_stream_writer: RTL and testbench

//  Bulk-load master upstream of the AXI4 RAM slave: accepts a valid/ready word stream and writes it to

---
 rtl/axi_stream_writer.sv | 181 ++++++++++++++++++
 tb/tb_axi_stream_writer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_writer.sv
// Stream-to-AXI4 bulk writer: turns a valid/ready word stream into INCR write bursts at
// consecutive addresses, one burst outstanding, never crossing a 4 KB boundary.
module axi_stream_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [COUNT_WIDTH-1:0] cfg_word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [ID_WIDTH-1:0]    m_axi_awid,
  output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awlock,
  output logic [3:0]             m_axi_awcache,
  output logic [2:0]             m_axi_awprot,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [DATA_WIDTH-1:0]  m_axi_wdata,
  output logic [STRB_WIDTH-1:0]  m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [ID_WIDTH-1:0]    m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready
);

  localparam int SIZE      = $clog2(STRB_WIDTH);
  localparam int PAGE_BITS = (ADDR_WIDTH < 12) ? ADDR_WIDTH : 12;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  logic [1:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [8:0]             r_beats;
  logic [8:0]             r_beat_cnt;
  logic [7:0]             r_awlen;
  logic                   r_awvalid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic [ADDR_WIDTH-1:0]  w_base_aligned;
  logic [ADDR_WIDTH-1:0]  w_step;
  logic [ADDR_WIDTH-1:0]  w_next_addr;
  logic [COUNT_WIDTH-1:0] w_next_rem;
  logic [PAGE_BITS-1:0]   w_calc_addr;
  logic [COUNT_WIDTH-1:0] w_calc_rem;
  logic [8:0]             w_calc_beats;
  logic                   w_in_w;
  logic                   w_unused_bid;

  // Burst length is the smallest of words left, the burst cap and the beats left in this 4 KB page.
  function automatic logic [8:0] calcBeats(input logic [PAGE_BITS-1:0] a_low,
                                           input logic [COUNT_WIDTH-1:0] rem);
    logic [31:0] page;
    logic [31:0] b;
    page = ((32'd1 << PAGE_BITS) - 32'(a_low)) >> SIZE;
    b    = 32'(MAX_BURST_LEN);
    if (32'(rem) < b) b = 32'(rem);
    if (page < b) b = page;
    return 9'(b);
  endfunction

  assign w_base_aligned = cfg_base_addr & ALIGN_MASK;
  assign w_step         = ADDR_WIDTH'(32'(r_beats) << SIZE);
  assign w_next_addr    = r_addr + w_step;
  assign w_next_rem     = r_remaining - COUNT_WIDTH'(r_beats);
  assign w_calc_addr    = (r_state == S_IDLE) ? w_base_aligned[PAGE_BITS-1:0] : w_next_addr[PAGE_BITS-1:0];
  assign w_calc_rem     = (r_state == S_IDLE) ? cfg_word_count : w_next_rem;
  assign w_calc_beats   = calcBeats(w_calc_addr, w_calc_rem);
  assign w_in_w         = (r_state == S_W);
  assign w_unused_bid   = ^m_axi_bid;

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign s_ready       = w_in_w && m_axi_wready;
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = w_in_w && s_valid;
  assign m_axi_wlast   = w_in_w && (r_beat_cnt == 9'd1);
  assign m_axi_bready  = (r_state == S_B);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_beat_cnt  <= '0;
      r_awlen     <= '0;
      r_awvalid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_addr      <= w_base_aligned;
            r_remaining <= cfg_word_count;
            r_err       <= 1'b0;
            if (cfg_word_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy    <= 1'b1;
              r_state   <= S_AW;
              r_awvalid <= 1'b1;
              r_beats   <= w_calc_beats;
              r_awlen   <= 8'(w_calc_beats - 9'd1);
            end
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= r_beats;
            r_state    <= S_W;
          end
        end
        S_W: begin
          if (s_valid && m_axi_wready) begin
            r_beat_cnt <= r_beat_cnt - 9'd1;
            if (r_beat_cnt == 9'd1) r_state <= S_B;
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) r_err <= 1'b1;
            r_remaining <= w_next_rem;
            r_addr      <= w_next_addr;
            if (w_next_rem == '0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_AW;
              r_awvalid <= 1'b1;
              r_beats   <= w_calc_beats;
              r_awlen   <= 8'(w_calc_beats - 9'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_writer.sv
// Bench for axi_stream_writer: a RAM-backed AXI slave model plus queues of expected AW
// and W beats that are consumed as the DUT presents handshakes.
module tb_axi_stream_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [15:0] cfg_base_addr;
  logic [15:0] cfg_word_count;
  logic        busy, done, err;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  always #5 clk = ~clk;

  axi_stream_writer dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_word_count(cfg_word_count), .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } wExpT;

  wExpT        expW[$];
  logic [23:0] expAw[$];
  logic [31:0] ram [0:16383];

  int   vectors = 0;
  int   miscompares = 0;
  int   doneCount = 0;
  int   wBeats = 0;
  int   awCount = 0;
  int   burstIdx = 0;
  int   errBurst = -1;
  bit   stall = 1'b0;
  bit   abortStream = 1'b0;
  bit   bPending = 1'b0;
  bit   bErrFlag = 1'b0;
  bit   awActive = 1'b0;
  bit   prevPending = 1'b0;
  logic [23:0] prevAw;
  logic [15:0] curAddr;
  int   curBeat;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] wordValue(input int tag, input int i);
    return {tag[7:0], 8'h5A, i[15:0]};
  endfunction

  // Queue one expected AW plus its data beats; wlast goes on the final beat only.
  task automatic expectBurst(input logic [15:0] addr, input int len, input int tag, input int firstIdx);
    wExpT e;
    expAw.push_back({addr, 8'(len)});
    for (int k = 0; k <= len; k++) begin
      e.data = wordValue(tag, firstIdx + k);
      e.last = (k == len);
      expW.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] base, input int count, input int tag, input bit gaps);
    int  guard;
    bit  accepted;
    @(negedge clk);
    cfg_base_addr  = base;
    cfg_word_count = 16'(count);
    cfg_start      = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < count && !abortStream; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          s_valid = 1'b0;
          @(negedge clk);
        end
      end
      s_valid  = 1'b1;
      s_data   = wordValue(tag, i);
      guard    = 0;
      accepted = 1'b0;
      while (!accepted && !abortStream) begin
        #4;
        accepted = s_ready;
        @(negedge clk);
        guard++;
        if (!accepted && guard > 500) begin
          checkOutput("streamAccepted", 64'(guard), 64'(0));
          abortStream = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic checkRam(input logic [15:0] base, input int count, input int tag);
    int bad = 0;
    logic [15:0] idx;
    for (int i = 0; i < count; i++) begin
      idx = 16'(base >> 2) + 16'(i);
      if (ram[idx[13:0]] !== wordValue(tag, i)) bad++;
    end
    checkOutput("ramWords", 64'(bad), 64'(0));
  endtask

  task automatic finishTest(input int startDone, input bit expErr);
    int n = 0;
    while (doneCount == startDone && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("doneCount", 64'(doneCount - startDone), 64'(1));
    checkOutput("err", 64'(err), 64'(expErr));
    checkOutput("busyAfter", 64'(busy), 64'(0));
    checkOutput("awLeft", 64'(expAw.size()), 64'(0));
    checkOutput("wLeft", 64'(expW.size()), 64'(0));
  endtask

  // Slave model and monitor: drives ready/response at the falling edge, judges handshakes 4 ns later.
  initial begin
    wExpT        we;
    logic [23:0] ea;
    logic [15:0] a;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_bid     = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        bPending      = 1'b0;
        awActive      = 1'b0;
        prevPending   = 1'b0;
        expAw.delete();
        expW.delete();
      end else begin
        m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_wready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_axi_bvalid  = bPending;
        m_axi_bresp   = bErrFlag ? 2'b10 : 2'b00;
        #4;
        if (done) doneCount++;
        if (m_axi_awvalid) awCount++;
        if (m_axi_awvalid && prevPending)
          checkOutput("awStable", 64'({m_axi_awaddr, m_axi_awlen}), 64'(prevAw));
        prevPending = m_axi_awvalid && !m_axi_awready;
        prevAw      = {m_axi_awaddr, m_axi_awlen};
        if (m_axi_awvalid && m_axi_awready) begin
          checkOutput("awExpected", 64'(expAw.size() > 0), 64'(1));
          if (expAw.size() > 0) begin
            ea = expAw.pop_front();
            checkOutput("awAddrLen", 64'({m_axi_awaddr, m_axi_awlen}), 64'(ea));
          end
          curAddr  = m_axi_awaddr;
          curBeat  = 0;
          awActive = 1'b1;
        end
        if (m_axi_wvalid) checkOutput("wAfterAw", 64'(awActive), 64'(1));
        if (m_axi_wvalid && m_axi_wready) begin
          checkOutput("wExpected", 64'(expW.size() > 0), 64'(1));
          if (expW.size() > 0) begin
            we = expW.pop_front();
            checkOutput("wData", 64'(m_axi_wdata), 64'(we.data));
            checkOutput("wLast", 64'(m_axi_wlast), 64'(we.last));
          end
          a = curAddr + 16'(curBeat * 4);
          ram[a[15:2]] = m_axi_wdata;
          curBeat++;
          wBeats++;
          if (m_axi_wlast) begin
            bPending = 1'b1;
            bErrFlag = (burstIdx == errBurst);
            awActive = 1'b0;
          end
        end
        if (m_axi_bvalid && m_axi_bready) begin
          bPending = 1'b0;
          burstIdx++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startDone;
    int awBefore;
    int wBefore;
    int n;
    rst            = 1'b0;
    cfg_start      = 1'b0;
    cfg_base_addr  = 16'h0;
    cfg_word_count = 16'h0;
    s_data         = 32'h0;
    s_valid        = 1'b0;

    #12;
    checkOutput("rstBusy", 64'(busy), 64'(0));
    checkOutput("rstDone", 64'(done), 64'(0));
    checkOutput("rstErr", 64'(err), 64'(0));
    checkOutput("rstValids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_ready}), 64'(0));
    checkOutput("awConst", 64'({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                                m_axi_awcache, m_axi_awprot, m_axi_wstrb}),
                64'({8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF}));
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: base 0x0000, 40 words");
    burstIdx = 0; startDone = doneCount;
    expectBurst(16'h0000, 15, 1, 0);
    expectBurst(16'h0040, 15, 1, 16);
    expectBurst(16'h0080, 7, 1, 32);
    applyStimulus(16'h0000, 40, 1, 1'b0);
    finishTest(startDone, 1'b0);
    checkRam(16'h0000, 40, 1);

    $display("[TB] test 2: base 0x0FF0, 8 words across 4 KB");
    burstIdx = 0; startDone = doneCount;
    expectBurst(16'h0FF0, 3, 2, 0);
    expectBurst(16'h1000, 3, 2, 4);
    applyStimulus(16'h0FF0, 8, 2, 1'b0);
    finishTest(startDone, 1'b0);
    checkRam(16'h0FF0, 8, 2);

    $display("[TB] test 3: 100 words with stream gaps and slave stalls");
    burstIdx = 0; startDone = doneCount; stall = 1'b1;
    for (int k = 0; k < 6; k++) expectBurst(16'h0200 + 16'(k * 64), 15, 3, k * 16);
    expectBurst(16'h0380, 3, 3, 96);
    applyStimulus(16'h0200, 100, 3, 1'b1);
    finishTest(startDone, 1'b0);
    checkRam(16'h0200, 100, 3);
    stall = 1'b0;

    $display("[TB] test 4: SLVERR on second burst");
    burstIdx = 0; startDone = doneCount; errBurst = 1;
    expectBurst(16'h0400, 15, 4, 0);
    expectBurst(16'h0440, 15, 4, 16);
    applyStimulus(16'h0400, 32, 4, 1'b0);
    finishTest(startDone, 1'b1);
    checkRam(16'h0400, 32, 4);
    errBurst = -1;

    $display("[TB] test 5: zero count, then start while busy");
    startDone = doneCount; awBefore = awCount;
    @(negedge clk);
    cfg_base_addr = 16'h0500; cfg_word_count = 16'h0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    checkOutput("zeroDone", 64'(done), 64'(1));
    checkOutput("zeroBusy", 64'(busy), 64'(0));
    checkOutput("errCleared", 64'(err), 64'(0));
    @(negedge clk);
    #1;
    checkOutput("zeroDonePulse", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    checkOutput("zeroNoAw", 64'(awCount - awBefore), 64'(0));
    checkOutput("zeroDoneCount", 64'(doneCount - startDone), 64'(1));

    burstIdx = 0; startDone = doneCount;
    expectBurst(16'h0300, 3, 5, 0);
    fork
      applyStimulus(16'h0300, 4, 5, 1'b0);
      begin
        repeat (3) @(negedge clk);
        cfg_base_addr = 16'h0900; cfg_word_count = 16'd1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
      end
    join
    finishTest(startDone, 1'b0);
    checkRam(16'h0300, 4, 5);

    $display("[TB] test 6: reset during W_DATA, then clean restart");
    burstIdx = 0; startDone = doneCount; wBefore = wBeats;
    expectBurst(16'h0800, 15, 6, 0);
    expectBurst(16'h0840, 3, 6, 16);
    fork
      applyStimulus(16'h0800, 20, 6, 1'b0);
      begin
        n = 0;
        while (wBeats - wBefore < 5 && n < 200) begin
          @(negedge clk);
          n++;
        end
        #6 rst = 1'b0;
        #1;
        checkOutput("rstMidValids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'(0));
        checkOutput("rstMidBusy", 64'(busy), 64'(0));
        abortStream = 1'b1;
      end
    join
    @(negedge clk);
    #2 rst = 1'b1;
    abortStream = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstNoDone", 64'(doneCount - startDone), 64'(0));

    burstIdx = 0; startDone = doneCount;
    expectBurst(16'h0100, 4, 7, 0);
    applyStimulus(16'h0100, 5, 7, 1'b0);
    finishTest(startDone, 1'b0);
    checkRam(16'h0100, 5, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
